// File: rtl/dmem_pkg.sv
// Shared types and helpers for the RV32I data-memory access controller.
package dmem_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned WADDR_W  = 30;
    localparam int unsigned BE_W     = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic               we;
        logic [WADDR_W-1:0] addr;
        logic [BE_W-1:0]    be;
        logic [XLEN-1:0]    wdata;
    } bus_req_t;

    // Legal funct3 for the direction, and naturally aligned for its size.
    function automatic logic access_ok(input logic is_load, input logic [2:0] f3,
                                       input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = is_load;
            F3_HU:   ok = is_load & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [BE_W-1:0] be_of(input logic [1:0] size, input logic [1:0] off);
        logic [BE_W-1:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [XLEN-1:0] wdata_rep(input logic [1:0] size, input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] r;
        case (size)
            2'b00:   r = {4{wd[7:0]}};
            2'b01:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_ext.sv
// Picks the addressed byte/halfword from a read word and sign/zero-extends it.
module load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = 8'(rdata >> {addr, 3'b000});
    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ext = rdata;
        case (funct3)
            F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    ext = {{16{half_sel[15]}}, half_sel};
            F3_BU:   ext = {24'h0, byte_sel};
            F3_HU:   ext = {16'h0, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: req/ack SRAM bus, pipeline stall,
// load extension, misalignment and timeout reporting.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  Funct3_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] WData_i,
    output logic [31:0] MemData_o,
    output logic        Stall_o,
    output logic        Err_o,
    output logic        BusErr_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [29:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    bus_req_t      bus_q, bus_d;
    logic          req_q, req_d;
    logic          buserr_q, buserr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;

    logic          any_c, ok_c, go_c;
    logic [31:0]   ext;

    assign any_c = MemRead_i | MemWrite_i;
    assign ok_c  = (MemRead_i ^ MemWrite_i) & access_ok(MemRead_i, Funct3_i, Addr_i[1:0]);
    assign go_c  = (state_q == IDLE) & ok_c;

    // Combinational handshakes back to the pipeline; forced low while in reset.
    assign Stall_o = nRESET & (go_c | (state_q == WAIT));
    assign Err_o   = nRESET & (state_q == IDLE) & any_c & ~ok_c;

    assign MemData_o   = data_q;
    assign BusErr_o    = buserr_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = bus_q.we;
    assign mem_addr_o  = bus_q.addr;
    assign mem_be_o    = bus_q.be;
    assign mem_wdata_o = bus_q.wdata;

    load_ext u_load_ext (
        .rdata  (mem_rdata_i),
        .addr   (off_q),
        .funct3 (f3_q),
        .ext    (ext)
    );

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= IDLE;
            bus_q    <= '0;
            req_q    <= 1'b0;
            buserr_q <= 1'b0;
            cnt_q    <= '0;
            data_q   <= '0;
            f3_q     <= '0;
            off_q    <= '0;
        end else begin
            state_q  <= state_d;
            bus_q    <= bus_d;
            req_q    <= req_d;
            buserr_q <= buserr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
        end
    end

    // Result and bus-error registers only hold non-zero values during DONE.
    always_comb begin
        state_d  = state_q;
        bus_d    = bus_q;
        req_d    = req_q;
        buserr_d = 1'b0;
        cnt_d    = cnt_q;
        data_d   = 32'h0;
        f3_d     = f3_q;
        off_d    = off_q;
        case (state_q)
            IDLE: begin
                if (go_c) begin
                    bus_d.we    = MemWrite_i;
                    bus_d.addr  = Addr_i[31:2];
                    bus_d.be    = be_of(Funct3_i[1:0], Addr_i[1:0]);
                    bus_d.wdata = wdata_rep(Funct3_i[1:0], WData_i);
                    f3_d        = Funct3_i;
                    off_d       = Addr_i[1:0];
                    req_d       = 1'b1;
                    cnt_d       = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    data_d  = bus_q.we ? 32'h0 : ext;
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    req_d    = 1'b0;
                    buserr_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized self-checking bench for dmem_ctrl against an arithmetic access model.
module tb_dmem_ctrl;

    localparam int unsigned T = 4;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b1;
    logic        MemRead_i = 1'b0;
    logic        MemWrite_i = 1'b0;
    logic [2:0]  Funct3_i = 3'b0;
    logic [31:0] Addr_i = 32'h0;
    logic [31:0] WData_i = 32'h0;
    logic [31:0] MemData_o;
    logic        Stall_o;
    logic        Err_o;
    logic        BusErr_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [29:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        mem_ack_i = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;
    int txn_id = 0;

    always #5 CLK = ~CLK;

    dmem_ctrl #(.TIMEOUT(T)) dut (
        .CLK         (CLK),
        .nRESET      (nRESET),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .Funct3_i    (Funct3_i),
        .Addr_i      (Addr_i),
        .WData_i     (WData_i),
        .MemData_o   (MemData_o),
        .Stall_o     (Stall_o),
        .Err_o       (Err_o),
        .BusErr_o    (BusErr_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s (txn %0d): got 0x%08h, expected 0x%08h", tag, txn_id, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned acc_size(input logic [2:0] f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                       input logic [31:0] addr);
        if (rd == wr) return 1'b0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (wr && f3 > 3'd2) return 1'b0;
        return (addr % acc_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned sz;
        sz = acc_size(f3);
        return 4'(((1 << sz) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int unsigned sz;
        sz = acc_size(f3);
        r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] v, mask;
        int unsigned sz;
        sz   = acc_size(f3);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = (rdata >> (8 * (addr % 4))) & mask;
        if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- stimulus tasks ----------------
    // delay = index of the WAIT cycle carrying ack; delay >= T means no ack.
    task automatic run_access(input bit rd, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdata, input int delay);
        int          exp_wait;
        bit          tmo;
        logic [31:0] exp_data;
        int          stall_cnt;
        int          nreq;
        bit          fin;
        bit          dirty;
        txn_id++;
        stall_cnt = 0;
        nreq      = 0;
        fin       = 1'b0;
        dirty     = 1'b0;
        exp_wait  = (delay < int'(T)) ? delay + 1 : int'(T);
        tmo       = (delay >= int'(T));
        exp_data  = (rd && !tmo) ? model_load(f3, addr, rdata) : 32'h0;
        @(negedge CLK);
        MemRead_i   = rd;
        MemWrite_i  = !rd;
        Funct3_i    = f3;
        Addr_i      = addr;
        WData_i     = wd;
        mem_rdata_i = rdata;
        mem_ack_i   = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            if (c > 0) @(negedge CLK);
            #1;
            if (Stall_o) stall_cnt++;
            if (c == 0) begin
                check("detect_err", 32'(Err_o), 32'd0);
            end else if (mem_req_o) begin
                if (nreq == 0) begin
                    check("bus_addr", 32'(mem_addr_o), addr >> 2);
                    check("bus_be", 32'(mem_be_o), 32'(model_be(f3, addr)));
                    check("bus_we", 32'(mem_we_o), 32'(!rd));
                    if (!rd) check("bus_wdata", mem_wdata_o, model_wdata(f3, wd));
                end else if (mem_addr_o !== 30'(addr >> 2) || mem_be_o !== model_be(f3, addr)) begin
                    dirty = 1'b1;
                end
                if (MemData_o !== 32'h0 || BusErr_o !== 1'b0) dirty = 1'b1;
                mem_ack_i = (nreq == delay);
                nreq++;
                // Upstream inputs may wander while the bus is busy.
                Addr_i     = $urandom;
                WData_i    = $urandom;
                Funct3_i   = 3'($urandom);
                MemRead_i  = 1'($urandom);
                MemWrite_i = 1'($urandom);
            end else begin
                check("done_data", MemData_o, exp_data);
                check("done_buserr", 32'(BusErr_o), 32'(tmo));
                fin        = 1'b1;
                MemRead_i  = 1'b0;
                MemWrite_i = 1'b0;
                mem_ack_i  = 1'($urandom);
            end
        end
        check("finished", 32'(fin), 32'd1);
        check("req_cycles", 32'(nreq), 32'(exp_wait));
        check("stall_cycles", 32'(stall_cnt), 32'(exp_wait + 1));
        check("bus_hold", 32'(dirty), 32'd0);
    endtask

    task automatic run_illegal(input bit rd, input bit wr, input logic [2:0] f3,
                               input logic [31:0] addr);
        txn_id++;
        @(negedge CLK);
        MemRead_i  = rd;
        MemWrite_i = wr;
        Funct3_i   = f3;
        Addr_i     = addr;
        mem_ack_i  = 1'b0;
        #1;
        check("err", 32'(Err_o), 32'd1);
        check("err_stall", 32'(Stall_o), 32'd0);
        @(negedge CLK);
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        #1;
        check("err_noreq", 32'(mem_req_o), 32'd0);
        check("err_pulse", 32'(Err_o), 32'd0);
    endtask

    initial begin
        #1 nRESET = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_data", MemData_o, 32'h0);
        check("rst_stall", 32'(Stall_o), 32'd0);
        check("rst_err", 32'(Err_o), 32'd0);
        check("rst_buserr", 32'(BusErr_o), 32'd0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_bus", {mem_we_o, mem_be_o, mem_addr_o[26:0]} | mem_wdata_o, 32'h0);
        @(negedge CLK);
        nRESET = 1'b1;

        // Directed cases from the access table.
        run_access(1'b1, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        run_access(1'b1, 3'b000, 32'h103, 32'h0, 32'h80AA_BBCC, 1);
        run_access(1'b1, 3'b100, 32'h103, 32'h0, 32'h80AA_BBCC, 2);
        run_access(1'b0, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0, 3);
        run_access(1'b0, 3'b000, 32'h101, 32'h0000_005A, 32'h0, 0);
        run_access(1'b1, 3'b101, 32'h202, 32'h0, 32'h9876_5432, 0);
        run_illegal(1'b1, 1'b0, 3'b010, 32'h101);
        run_illegal(1'b1, 1'b1, 3'b000, 32'h100);
        run_illegal(1'b0, 1'b1, 3'b100, 32'h100);
        run_access(1'b1, 3'b010, 32'h300, 32'h0, 32'hFFFF_FFFF, 99);

        // Reset in the middle of WAIT.
        txn_id++;
        @(negedge CLK);
        MemRead_i = 1'b1; MemWrite_i = 1'b0; Funct3_i = 3'b010; Addr_i = 32'h200;
        mem_ack_i = 1'b0;
        @(negedge CLK);
        #1;
        check("mid_req", 32'(mem_req_o), 32'd1);
        #1 nRESET = 1'b0;
        #1;
        check("rstw_req", 32'(mem_req_o), 32'd0);
        check("rstw_stall", 32'(Stall_o), 32'd0);
        check("rstw_be", 32'(mem_be_o), 32'd0);
        @(negedge CLK);
        MemRead_i = 1'b0;
        @(negedge CLK);
        nRESET    = 1'b1;
        mem_ack_i = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            #1;
            check("late_ack_req", 32'(mem_req_o), 32'd0);
            check("late_ack_stall", 32'(Stall_o), 32'd0);
            check("late_ack_data", MemData_o, 32'h0);
        end
        mem_ack_i = 1'b0;
        run_access(1'b1, 3'b000, 32'h401, 32'h0, 32'h1234_7F00, 0);

        // Randomized mix, back-to-back.
        for (int i = 0; i < 250; i++) begin
            int unsigned mode;
            bit          rd, wr;
            logic [2:0]  f3;
            logic [31:0] addr;
            mode = $urandom_range(0, 9);
            rd   = (mode == 0) || (mode >= 1 && mode <= 5);
            wr   = (mode == 0) || (mode >= 6);
            f3   = 3'($urandom);
            addr = $urandom;
            if (model_legal(rd, wr, f3, addr))
                run_access(rd, f3, addr, $urandom, $urandom, int'($urandom_range(0, 5)));
            else
                run_illegal(rd, wr, f3, addr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, limit 400000", $time);
        $fatal(1);
    end

endmodule
